// File: rtl/rubik_wr_req_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : rubik_wr_req_unpack
//  Purpose  : Receives the multiplexed Rubik write-request packet stream
//             (command or data, selected by bit 514). It checks the packets
//             against the command/data framing rules and splits them into a
//             registered command channel and a registered data channel. It
//             also pulses a completion strobe when the last beat of an
//             acknowledged command is delivered downstream.
//  Ports    : nvdla_core_clk / nvdla_core_rstn  - clock, async active-low reset
//             wr_req_vld/rdy/pd                 - incoming 515-bit packet stream
//             cmd_vld/rdy, cmd_addr/size/ack    - command output channel
//             dat_vld/rdy, dat_data/mask/last   - data output channel
//             wr_done                           - acked command fully delivered
//             err_sticky / err_code             - first protocol error seen
//             cmd_cnt                           - forwarded command count
//  Revision : 1.0 - initial release
// ============================================================================
module rubik_wr_req_unpack (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         wr_req_vld,
    output logic         wr_req_rdy,
    input  logic [514:0] wr_req_pd,
    output logic         cmd_vld,
    input  logic         cmd_rdy,
    output logic [63:0]  cmd_addr,
    output logic [12:0]  cmd_size,
    output logic         cmd_ack,
    output logic         dat_vld,
    input  logic         dat_rdy,
    output logic [511:0] dat_data,
    output logic [1:0]   dat_mask,
    output logic         dat_last,
    output logic         wr_done,
    output logic         err_sticky,
    output logic [1:0]   err_code,
    output logic [15:0]  cmd_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    localparam logic [1:0] ERR_ORPHAN_DAT = 2'd1;
    localparam logic [1:0] ERR_CMD_IN_DAT = 2'd2;
    localparam logic [1:0] ERR_MASK       = 2'd3;

    state_t        state_q, state_d;
    logic [13:0]   remain_q, remain_d;
    logic          ack_pend_q, ack_pend_d;

    logic          cmd_vld_q;
    logic [63:0]   cmd_addr_q;
    logic [12:0]   cmd_size_q;
    logic          cmd_ack_q;
    logic          dat_vld_q;
    logic [511:0]  dat_data_q;
    logic [1:0]    dat_mask_q;
    logic          dat_last_q;
    logic          dat_ack_q;
    logic          err_sticky_q;
    logic [1:0]    err_code_q;
    logic [15:0]   cmd_cnt_q;

    logic          w_is_dat;
    logic          w_cmd_fwd;
    logic          w_dat_fwd;
    logic          w_drop;
    logic          w_acc;
    logic          w_cmd_load;
    logic          w_dat_load;
    logic [1:0]    w_exp_mask;
    logic [13:0]   w_remain_dec;
    logic          w_err_evt;
    logic [1:0]    w_err_code;

    // ------------------------------------------------------------------
    // Packet classification and input ready
    // ------------------------------------------------------------------
    assign w_is_dat  = wr_req_pd[514];
    assign w_cmd_fwd = ~w_is_dat & (state_q == ST_IDLE);
    assign w_dat_fwd =  w_is_dat & (state_q == ST_DATA);
    // Anything out of place is swallowed immediately so the stream never stalls
    assign w_drop    = ~w_cmd_fwd & ~w_dat_fwd;

    assign wr_req_rdy = w_drop
                      | (w_cmd_fwd & (~cmd_vld_q | cmd_rdy))
                      | (w_dat_fwd & (~dat_vld_q | dat_rdy));

    assign w_acc      = wr_req_vld & wr_req_rdy;
    assign w_cmd_load = w_acc & w_cmd_fwd;
    assign w_dat_load = w_acc & w_dat_fwd;

    // A lone half is owed only when remain is 1; otherwise a full beat
    assign w_exp_mask   = (remain_q == 14'd1) ? 2'b01 : 2'b11;
    assign w_remain_dec = remain_q - ((remain_q == 14'd1) ? 14'd1 : 14'd2);

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= ST_IDLE;
            remain_q   <= 14'd0;
            ack_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            ack_pend_q <= ack_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        ack_pend_d = ack_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (w_cmd_load) begin
                    state_d    = ST_DATA;
                    remain_d   = {1'b0, wr_req_pd[76:64]} + 14'd1;
                    ack_pend_d = wr_req_pd[77];
                end
            end
            ST_DATA: begin
                if (w_dat_load) begin
                    remain_d = w_remain_dec;
                    if (w_remain_dec == 14'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Error detection
    // ------------------------------------------------------------------
    always_comb begin
        w_err_evt  = 1'b0;
        w_err_code = 2'd0;
        if (w_acc & w_drop) begin
            w_err_evt  = 1'b1;
            w_err_code = w_is_dat ? ERR_ORPHAN_DAT : ERR_CMD_IN_DAT;
        end else if (w_dat_load && (wr_req_pd[513:512] != w_exp_mask)) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_MASK;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_sticky_q <= 1'b0;
            err_code_q   <= 2'd0;
        end else if (w_err_evt) begin
            err_sticky_q <= 1'b1;
            if (!err_sticky_q) begin
                err_code_q <= w_err_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command output register (load wins over pop for back-to-back flow)
    // ------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cmd_vld_q  <= 1'b0;
            cmd_addr_q <= 64'd0;
            cmd_size_q <= 13'd0;
            cmd_ack_q  <= 1'b0;
            cmd_cnt_q  <= 16'd0;
        end else begin
            if (w_cmd_load) begin
                cmd_vld_q  <= 1'b1;
                cmd_addr_q <= wr_req_pd[63:0];
                cmd_size_q <= wr_req_pd[76:64];
                cmd_ack_q  <= wr_req_pd[77];
                cmd_cnt_q  <= cmd_cnt_q + 16'd1;
            end else if (cmd_rdy) begin
                cmd_vld_q  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data output register; the ack bit travels with the beat so wr_done
    // stays correct even after a new command has been accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dat_vld_q  <= 1'b0;
            dat_data_q <= 512'd0;
            dat_mask_q <= 2'd0;
            dat_last_q <= 1'b0;
            dat_ack_q  <= 1'b0;
        end else begin
            if (w_dat_load) begin
                dat_vld_q  <= 1'b1;
                dat_data_q <= wr_req_pd[511:0];
                dat_mask_q <= wr_req_pd[513:512];
                dat_last_q <= (w_remain_dec == 14'd0);
                dat_ack_q  <= ack_pend_q;
            end else if (dat_rdy) begin
                dat_vld_q  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_vld    = cmd_vld_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_size   = cmd_size_q;
    assign cmd_ack    = cmd_ack_q;
    assign dat_vld    = dat_vld_q;
    assign dat_data   = dat_data_q;
    assign dat_mask   = dat_mask_q;
    assign dat_last   = dat_last_q;
    assign wr_done    = dat_vld_q & dat_rdy & dat_last_q & dat_ack_q;
    assign err_sticky = err_sticky_q;
    assign err_code   = err_code_q;
    assign cmd_cnt    = cmd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rubik_wr_req_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rubik_wr_req_unpack
//  Purpose  : Self-checking bench for rubik_wr_req_unpack. A behavioural
//             model tracks the halves still owed, the two single-entry
//             output registers and the error/command counters. Every cycle
//             the DUT outputs are compared against the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rubik_wr_req_unpack;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         wr_req_vld = 1'b0;
    logic         wr_req_rdy;
    logic [514:0] wr_req_pd = '0;
    logic         cmd_vld;
    logic         cmd_rdy = 1'b0;
    logic [63:0]  cmd_addr;
    logic [12:0]  cmd_size;
    logic         cmd_ack;
    logic         dat_vld;
    logic         dat_rdy = 1'b0;
    logic [511:0] dat_data;
    logic [1:0]   dat_mask;
    logic         dat_last;
    logic         wr_done;
    logic         err_sticky;
    logic [1:0]   err_code;
    logic [15:0]  cmd_cnt;

    rubik_wr_req_unpack dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wr_req_vld      (wr_req_vld),
        .wr_req_rdy      (wr_req_rdy),
        .wr_req_pd       (wr_req_pd),
        .cmd_vld         (cmd_vld),
        .cmd_rdy         (cmd_rdy),
        .cmd_addr        (cmd_addr),
        .cmd_size        (cmd_size),
        .cmd_ack         (cmd_ack),
        .dat_vld         (dat_vld),
        .dat_rdy         (dat_rdy),
        .dat_data        (dat_data),
        .dat_mask        (dat_mask),
        .dat_last        (dat_last),
        .wr_done         (wr_done),
        .err_sticky      (err_sticky),
        .err_code        (err_code),
        .cmd_cnt         (cmd_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int rdy_pct = 100;

    // Behavioural model
    int           owed;
    bit           m_ackp;
    bit           m_cocc;
    logic [63:0]  m_caddr;
    logic [12:0]  m_csize;
    bit           m_cack;
    bit           m_docc;
    logic [511:0] m_ddata;
    logic [1:0]   m_dmask;
    bit           m_dlast;
    bit           m_dack;
    bit           m_err;
    logic [1:0]   m_ecode;
    int           m_cnt;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [514:0] mk_cmd(input logic [63:0] a, input logic [12:0] s, input logic k);
        return {1'b0, 436'd0, k, s, a};
    endfunction

    function automatic logic [514:0] mk_dat(input logic [511:0] d, input logic [1:0] m);
        return {1'b1, m, d};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit rr();
        return ($urandom_range(99) < rdy_pct);
    endfunction

    function automatic logic m_rdy(input logic [514:0] pd, input logic crdy, input logic drdy);
        if (!pd[514]) return (owed == 0) ? (!m_cocc || crdy) : 1'b1;
        return (owed != 0) ? (!m_docc || drdy) : 1'b1;
    endfunction

    function automatic void m_err_set(input logic [1:0] code);
        if (!m_err) m_ecode = code;
        m_err = 1'b1;
    endfunction

    function automatic void m_reset();
        owed = 0; m_ackp = 0; m_cocc = 0; m_docc = 0;
        m_caddr = '0; m_csize = '0; m_cack = 0;
        m_ddata = '0; m_dmask = '0; m_dlast = 0; m_dack = 0;
        m_err = 0; m_ecode = '0; m_cnt = 0;
    endfunction

    function automatic void m_accept(input logic [514:0] pd);
        int take;
        logic [1:0] em;
        if (!pd[514]) begin
            if (owed == 0) begin
                m_caddr = pd[63:0];
                m_csize = pd[76:64];
                m_cack  = pd[77];
                m_cocc  = 1;
                owed    = int'(pd[76:64]) + 1;
                m_ackp  = pd[77];
                m_cnt   = (m_cnt + 1) % 65536;
            end else begin
                m_err_set(2'd2);
            end
        end else begin
            if (owed == 0) begin
                m_err_set(2'd1);
            end else begin
                take = (owed == 1) ? 1 : 2;
                em   = (owed == 1) ? 2'b01 : 2'b11;
                if (pd[513:512] != em) m_err_set(2'd3);
                owed    = owed - take;
                m_ddata = pd[511:0];
                m_dmask = pd[513:512];
                m_dlast = (owed == 0);
                m_dack  = m_ackp;
                m_docc  = 1;
            end
        end
    endfunction

    // One clock cycle: drive at negedge, compare, then advance the model
    task automatic step(input logic vld, input logic [514:0] pd, input logic crdy,
                        input logic drdy, output bit acc);
        logic exp_rdy;
        @(negedge clk);
        wr_req_vld = vld;
        wr_req_pd  = pd;
        cmd_rdy    = crdy;
        dat_rdy    = drdy;
        #1;
        exp_rdy = m_rdy(pd, crdy, drdy);
        chk("wr_req_rdy", wr_req_rdy, exp_rdy);
        chk("cmd_vld", cmd_vld, m_cocc);
        if (m_cocc) begin
            chk("cmd_addr", cmd_addr, m_caddr);
            chk("cmd_size", cmd_size, m_csize);
            chk("cmd_ack", cmd_ack, m_cack);
        end
        chk("dat_vld", dat_vld, m_docc);
        if (m_docc) begin
            chk("dat_data", dat_data, m_ddata);
            chk("dat_mask", dat_mask, m_dmask);
            chk("dat_last", dat_last, m_dlast);
        end
        chk("wr_done", wr_done, m_docc && drdy && m_dlast && m_dack);
        chk("err_sticky", err_sticky, m_err);
        chk("err_code", err_code, m_ecode);
        chk("cmd_cnt", cmd_cnt, m_cnt[15:0]);
        if (wr_done === 1'b1) n_done++;
        acc = vld && exp_rdy;
        if (m_cocc && crdy) m_cocc = 0;
        if (m_docc && drdy) m_docc = 0;
        if (acc) m_accept(pd);
    endtask

    task automatic send(input logic [514:0] pd);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, pd, rr(), rr(), acc);
            n++;
        end while (!acc && n < 100);
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, rr(), rr(), acc);
    endtask

    // Sends the correctly framed beats for a command; bad_first corrupts beat 1's mask
    task automatic send_beats(input int size, input bit bad_first);
        int h;
        logic [1:0] m;
        bit first;
        h = size + 1;
        first = 1;
        while (h > 0) begin
            m = (h == 1) ? 2'b01 : 2'b11;
            if (first && bad_first) m = m ^ 2'b10;
            send(mk_dat(rnd512(), m));
            h = h - ((h == 1) ? 1 : 2);
            first = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn       = 1'b0;
        wr_req_vld = 1'b0;
        wr_req_pd  = '0;
        cmd_rdy    = 1'b0;
        dat_rdy    = 1'b0;
        m_reset();
        #1;
        chk("rst_cmd_vld", cmd_vld, 1'b0);
        chk("rst_dat_vld", dat_vld, 1'b0);
        chk("rst_wr_done", wr_done, 1'b0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        chk("rst_err_code", err_code, 2'd0);
        chk("rst_cmd_cnt", cmd_cnt, 16'd0);
        chk("rst_cmd_addr", cmd_addr, 64'd0);
        chk("rst_cmd_size", cmd_size, 13'd0);
        chk("rst_cmd_ack", cmd_ack, 1'b0);
        chk("rst_dat_data", dat_data, 512'd0);
        chk("rst_dat_mask", dat_mask, 2'd0);
        chk("rst_dat_last", dat_last, 1'b0);
        chk("rst_wr_req_rdy", wr_req_rdy, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bit acc;
        int done0;
        int sz;
        int r;
        m_reset();
        do_reset();

        // Size 3 with ack: two full beats, one wr_done
        rdy_pct = 100;
        done0 = n_done;
        send(mk_cmd(64'h1000, 13'd3, 1'b1));
        send_beats(3, 1'b0);
        idle(3);
        chk("t1_wr_done_count", n_done - done0, 1);
        chk("t1_cmd_cnt", cmd_cnt, 16'd1);

        // Size 2: masks 11 then 01; FSM back in IDLE so a new cmd is clean
        send(mk_cmd(64'h2000, 13'd2, 1'b0));
        send_beats(2, 1'b0);
        idle(2);
        send(mk_cmd(64'h3000, 13'd0, 1'b1));
        send_beats(0, 1'b0);
        idle(2);
        chk("t2_err_sticky", err_sticky, 1'b0);

        // Size 1 with a lone-half mask: forwarded, error 3, still last
        do_reset();
        send(mk_cmd(64'h4000, 13'd1, 1'b1));
        send(mk_dat(rnd512(), 2'b01));
        idle(2);
        chk("t4_err_code", err_code, 2'd3);

        // Orphan data in IDLE: dropped, error 1, then normal command flow
        do_reset();
        send(mk_dat(rnd512(), 2'b11));
        idle(2);
        chk("t3_err_code", err_code, 2'd1);
        send(mk_cmd(64'h5000, 13'd4, 1'b1));
        send_beats(4, 1'b0);
        idle(2);

        // 4-beat transfer with dat_rdy held low for 5 cycles
        send(mk_cmd(64'h6000, 13'd7, 1'b1));
        idle(1);
        step(1'b1, mk_dat(512'hA1, 2'b11), 1'b1, 1'b0, acc);
        chk("t5_beat1_acc", acc, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk_dat(512'hA2, 2'b11), 1'b1, 1'b0, acc);
            chk("t5_stall", acc, 1'b0);
        end
        send(mk_dat(512'hA2, 2'b11));
        send(mk_dat(512'hA3, 2'b11));
        send(mk_dat(512'hA4, 2'b11));
        idle(3);

        // Reset after beat 1 of a 3-beat command
        send(mk_cmd(64'h7000, 13'd5, 1'b1));
        step(1'b1, mk_dat(512'hB1, 2'b11), 1'b1, 1'b0, acc);
        chk("t6_beat1_acc", acc, 1'b1);
        do_reset();
        send(mk_cmd(64'h8000, 13'd0, 1'b0));
        send_beats(0, 1'b0);
        idle(2);
        chk("t6_err_sticky", err_sticky, 1'b0);
        chk("t6_cmd_cnt", cmd_cnt, 16'd1);

        // Randomized traffic with backpressure and occasional protocol errors
        rdy_pct = 60;
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(9);
            sz = $urandom_range(9);
            if (r == 0) begin
                send(mk_dat(rnd512(), 2'($urandom_range(3))));
            end else begin
                send(mk_cmd({$urandom, $urandom}, 13'(sz), 1'($urandom_range(1))));
                if (r == 1) send(mk_cmd(64'hDEAD, 13'd3, 1'b1));
                send_beats(sz, r == 2);
            end
            idle($urandom_range(2));
        end
        rdy_pct = 100;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
